// File: rtl/contador_programavel.sv
// contador_programavel: programmable up/down counter with a limit that can be
// changed at run time, continuous (auto-reload) or one-shot operation, a count
// enable, a synchronous restart and a registered terminal flag (fim).
// This is the timing base for traffic-light phases and pattern-detector timeouts.
//
// Optional build feature: define CONTADOR_PRESCALER_EN to divide the count
// enable by PRESCALE. In that build the counter advances only on every
// PRESCALE-th cycle in which habilita is high. Without the macro, every cycle
// with habilita high advances the counter and PRESCALE has no effect.
//
// Controller state decodes directly onto the outputs:
//   IDLE     -> ativo=0, concluido=0
//   CONTANDO -> ativo=1
//   PARADO   -> concluido=1
//
// Handshake: none. The inputs are level controls sampled at each rising edge.
// Any edge where tick is high advances the counter. reiniciar takes priority
// over tick.
module contador_programavel #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilita,
    input  logic             reiniciar,
    input  logic             direcao,
    input  logic             modo_unico,
    input  logic [WIDTH-1:0] valor_maximo,
    output logic [WIDTH-1:0] contagem,
    output logic             fim,
    output logic             ativo,
    output logic             concluido
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONTANDO = 2'd1,
        PARADO   = 2'd2
    } estado_t;

    // Registered state
    estado_t          r_estado;
    logic [WIDTH-1:0] r_contagem;
    logic             r_fim;
    logic [WIDTH-1:0] r_limite;
    logic             r_dir;
    logic             r_unico;

    // Next-state values
    estado_t          w_estado_prox;
    logic [WIDTH-1:0] w_contagem_prox;
    logic             w_fim_prox;
    logic [WIDTH-1:0] w_limite_prox;
    logic             w_dir_prox;
    logic             w_unico_prox;
    logic             w_carregar;

    // Decoded helpers
    logic             w_tick;
    logic [WIDTH-1:0] w_terminal;
    logic             w_no_terminal;

`ifdef CONTADOR_PRESCALER_EN
    // The divider is at least 1 bit wide, so PRESCALE=1 still elaborates.
    // With PRESCALE=1 the divider stays at 0 and every enabled cycle is a tick.
    localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  DIV_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_div;

    // The divider counts only on enabled cycles and wraps at PRESCALE-1.
    // reiniciar clears it, so a restarted period begins a fresh division.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (reiniciar) begin
            r_div <= '0;
        end else if (habilita) begin
            if (r_div == DIV_MAX) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + PW'(1);
            end
        end
    end

    assign w_tick = habilita & (r_div == DIV_MAX);
`else
    // Undivided enable. A non-positive ratio is illegal in any build, and here
    // it simply stops the counter from advancing.
    assign w_tick = habilita & (PRESCALE >= 1);
`endif

    // The terminal value for the current period comes from the latched direction.
    assign w_terminal    = r_dir ? '0 : r_limite;
    assign w_no_terminal = (r_contagem == w_terminal);

    // Next-state and datapath logic. Everything holds unless there is a tick or
    // a restart.
    always_comb begin
        w_estado_prox   = r_estado;
        w_contagem_prox = r_contagem;
        w_fim_prox      = r_fim;
        w_limite_prox   = r_limite;
        w_dir_prox      = r_dir;
        w_unico_prox    = r_unico;
        w_carregar      = 1'b0;

        if (reiniciar) begin
            w_estado_prox   = IDLE;
            w_contagem_prox = '0;
            w_fim_prox      = 1'b0;
            w_limite_prox   = '0;
            w_dir_prox      = 1'b0;
            w_unico_prox    = 1'b0;
        end else if (w_tick) begin
            case (r_estado)
                IDLE: begin
                    w_carregar    = 1'b1;
                    w_estado_prox = CONTANDO;
                end
                CONTANDO: begin
                    if (!w_no_terminal) begin
                        // Stepping stops at the terminal value, so the count never
                        // wraps past 0 or past the limit.
                        if (r_dir) begin
                            w_contagem_prox = r_contagem - WIDTH'(1);
                        end else begin
                            w_contagem_prox = r_contagem + WIDTH'(1);
                        end
                    end else if (!r_unico) begin
                        // Start a new period. Input changes made during the
                        // period take effect only here.
                        w_carregar = 1'b1;
                    end else begin
                        w_estado_prox = PARADO;
                    end
                end
                PARADO: begin
                    // Stays here until restart or reset; the count holds.
                end
                default: begin
                    w_estado_prox = IDLE;
                end
            endcase

            if (w_carregar) begin
                w_limite_prox   = valor_maximo;
                w_dir_prox      = direcao;
                w_unico_prox    = modo_unico;
                w_contagem_prox = direcao ? valor_maximo : '0;
            end

            // fim follows the next count, so it is high in the same cycle that
            // the terminal value appears on contagem.
            w_fim_prox = (w_estado_prox == CONTANDO) &&
                         (w_contagem_prox == (w_dir_prox ? '0 : w_limite_prox));
        end
    end

    // State and datapath registers, with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado   <= IDLE;
            r_contagem <= '0;
            r_fim      <= 1'b0;
            r_limite   <= '0;
            r_dir      <= 1'b0;
            r_unico    <= 1'b0;
        end else begin
            r_estado   <= w_estado_prox;
            r_contagem <= w_contagem_prox;
            r_fim      <= w_fim_prox;
            r_limite   <= w_limite_prox;
            r_dir      <= w_dir_prox;
            r_unico    <= w_unico_prox;
        end
    end

    assign contagem  = r_contagem;
    assign fim       = r_fim;
    assign ativo     = (r_estado == CONTANDO);
    assign concluido = (r_estado == PARADO);

endmodule

// File: doc/contador_programavel.md
Name: contador_programavel

Overview:
- Parametrised successor to the single-mode 5-bit counter used by the traffic-light and pattern-detector blocks.
- Counts up or down to a programmable limit, either continuously (auto-reload) or one-shot.
- Supports count-enable, synchronous restart and a registered terminal flag.
- Serves as the timing base for traffic-light phase durations and pattern-detector timeouts.

Parameters:
- WIDTH, 5: bit width of valor_maximo and contagem. Legal range 2..16.
- PRESCALE, 4: tick divider ratio. Used only when CONTADOR_PRESCALER_EN is defined. Must be ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- habilita  input  1  count enable. When low, all state holds.
- reiniciar  input  1  synchronous restart to IDLE. Overrides habilita.
- direcao  input  1  0 = count up (0→limite), 1 = count down (limite→0). Sampled at period start.
- modo_unico  input  1  1 = one-shot, 0 = continuous. Sampled at period start.
- valor_maximo  input  WIDTH  terminal value (limite). Sampled at period start.
- contagem  output  WIDTH  current count (registered).
- fim  output  1  high while contagem equals the terminal value in CONTANDO (registered with contagem).
- ativo  output  1  high in CONTANDO.
- concluido  output  1  high in PARADO.

Behaviour:
- Reset (async, active-high): state=IDLE; contagem=0; fim=0; ativo=0; concluido=0; latched limite, dir and unico registers cleared to 0.
- tick = habilita, or the prescaled enable when the optional feature is compiled in. With no tick, every register holds, including fim.
- reiniciar=1 at an edge forces IDLE and the reset values of all outputs, regardless of tick. The prescaler also clears.
- States:
  - IDLE: on tick, latch limite=valor_maximo, dir=direcao, unico=modo_unico. Load contagem with the start value (0 if up, valor_maximo if down). Go to CONTANDO.
  - CONTANDO: on tick, if contagem≠terminal, step by ±1. Terminal is limite (up) or 0 (down).
    - If contagem==terminal and unico=0: re-sample all three inputs and load the new start value. A period is therefore limite+1 ticks, and mid-period changes to inputs take effect only at the next period.
    - If contagem==terminal and unico=1: go to PARADO; contagem holds the terminal value.
  - PARADO: contagem holds; fim=0; concluido=1. Leaves only via reiniciar or reset.
- fim is computed from the next-state value, so it rises in the same cycle contagem shows the terminal value and falls on the following tick.
- valor_maximo=0: the start value equals the terminal value.
  - Continuous: contagem stays 0 and fim stays 1 on every tick.
  - One-shot: fim=1 for one tick, then PARADO.
- No wrap beyond limite. Arithmetic is unsigned WIDTH-bit; up-count never exceeds 2^WIDTH−1 and down-count never goes below 0.
- Reset asserted mid-period returns outputs to reset values immediately, without waiting for clk.

Optional Feature:
- Macro CONTADOR_PRESCALER_EN.
- Defined: an internal divider counts 0..PRESCALE−1 on cycles with habilita=1 and holds when habilita=0. tick pulses only when habilita=1 and the divider is at PRESCALE−1. The divider clears on reset and reiniciar. PRESCALE=1 behaves identically to the undefined case.
- Undefined: tick=habilita; no divider logic is instantiated and PRESCALE is ignored.

Test Plan:
- Up, continuous, valor_maximo=3, habilita=1 → contagem 0,1,2,3,0,1…; fim high only on 3; ativo=1.
- Down, one-shot, valor_maximo=5 → contagem 5,4,3,2,1,0; fim=1 on 0; next tick concluido=1, fim=0; contagem holds 0 until reiniciar.
- Continuous up, limite=10; change valor_maximo to 15 at count 4 → period ends at 10; next period runs 0..15.
- habilita low for 3 cycles at count 2 → contagem and fim frozen. reiniciar=1 with habilita=1 → IDLE, contagem=0.
- valor_maximo=0, continuous → fim constantly 1, contagem 0. Assert reset asynchronously mid-cycle → all outputs 0 before the next edge.
- CONTADOR_PRESCALER_EN, PRESCALE=4, valor_maximo=2 → contagem advances every 4th enabled cycle; a full period takes 12 cycles.
